// File: rtl/fu_scoreboard.sv
// fu_scoreboard: issue/writeback controller for the multicycle EXE units.
// One entry per unit tracks the destination of the in-flight operation; the
// entries drive structural/RAW/WAW stalls at issue, and a fixed-priority or
// round-robin arbiter serialises unit completions onto the single result path.

// Per-unit entry: holds busy/rd/rd_fp/wr and compares them against the
// instruction currently in ID.
module fu_sb_entry #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              issue_wr,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_rd_fp,
    input  logic [2:0][REG_AW-1:0] rs_id,
    input  logic [2:0]        rs_fp,
    input  logic [2:0]        use_rs,
    output logic              busy,
    output logic              raw_hit,
    output logic              waw_hit
);
    typedef struct packed {
        logic              busy;
        logic              wr;
        logic              rd_fp;
        logic [REG_AW-1:0] rd;
    } entry_t;

    entry_t ent;

    // A source hits when it is read, names this entry's destination in the
    // same register file, and is not integer x0 (FP f0 is a real register).
    function automatic logic src_hit(input logic use_s, input logic [REG_AW-1:0] rs,
                                     input logic fp);
        return use_s && ent.busy && ent.wr && (ent.rd == rs) && (ent.rd_fp == fp) &&
               (fp || (rs != '0));
    endfunction

    // Entry state: load on accepted issue, release on writeback grant.
    // Load and clear never coincide: a busy unit blocks its own issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent <= '0;
        end else if (load) begin
            ent <= '{busy: 1'b1, wr: issue_wr, rd_fp: issue_rd_fp, rd: issue_rd};
        end else if (clear) begin
            ent.busy <= 1'b0;
        end
    end

    // Hazard compare against the registered entry only.
    always_comb begin
        busy    = ent.busy;
        raw_hit = src_hit(use_rs[0], rs_id[0], rs_fp[0]) |
                  src_hit(use_rs[1], rs_id[1], rs_fp[1]) |
                  src_hit(use_rs[2], rs_id[2], rs_fp[2]);
        waw_hit = issue_wr && ent.busy && ent.wr && (ent.rd == issue_rd) &&
                  (ent.rd_fp == issue_rd_fp);
    end
endmodule

module fu_scoreboard #(
    parameter int NUM_FU = 9,
    parameter int REG_AW = 5,
    parameter bit RR_ARB = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [NUM_FU-1:0] issue_fu,
    input  logic              issue_wr,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_rd_fp,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rs3_id,
    input  logic              rs1_fp,
    input  logic              rs2_fp,
    input  logic              rs3_fp,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              use_rs3,
    input  logic [NUM_FU-1:0] fu_done,
    output logic [NUM_FU-1:0] wb_grant,
    output logic [NUM_FU-1:0] fu_hold,
    output logic              issue_stall,
    output logic              issue_accept,
    output logic [NUM_FU-1:0] busy,
    output logic              empty,
    output logic              err_spurious
);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [2:0][REG_AW-1:0] rs_id;
    logic [2:0]             rs_fp;
    logic [2:0]             use_rs;
    logic [NUM_FU-1:0]      raw_vec;
    logic [NUM_FU-1:0]      waw_vec;
    logic [NUM_FU-1:0]      load;
    logic [NUM_FU-1:0]      req;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          gidx;
    logic                   found;

    assign rs_id  = {rs3_id, rs2_id, rs1_id};
    assign rs_fp  = {rs3_fp, rs2_fp, rs1_fp};
    assign use_rs = {use_rs3, use_rs2, use_rs1};

    // One entry per functional unit.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_ent
        fu_sb_entry #(.REG_AW(REG_AW)) u_ent (
            .clk         (clk),
            .rst         (rst),
            .load        (load[i]),
            .clear       (wb_grant[i]),
            .issue_wr    (issue_wr),
            .issue_rd    (issue_rd),
            .issue_rd_fp (issue_rd_fp),
            .rs_id       (rs_id),
            .rs_fp       (rs_fp),
            .use_rs      (use_rs),
            .busy        (busy[i]),
            .raw_hit     (raw_vec[i]),
            .waw_hit     (waw_vec[i])
        );
    end

    // Issue control: structural, RAW and WAW stalls from registered entries.
    always_comb begin
        issue_stall  = issue_valid & ((|(busy & issue_fu)) | (|raw_vec) | (|waw_vec));
        issue_accept = issue_valid & ~issue_stall;
        load         = issue_accept ? issue_fu : '0;
        empty        = ~|busy;
    end

    // Writeback arbiter: scan from ptr (round-robin) or from 0 (fixed) and
    // grant the first requesting busy unit; losers are held.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        req      = fu_done & busy;
        wb_grant = '0;
        gidx     = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = (RR_ARB ? {1'b0, ptr} : '0) + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_FU)) sum = sum - (PW+1)'(NUM_FU);
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found         = 1'b1;
                wb_grant[idx] = 1'b1;
                gidx          = idx;
            end
        end
        fu_hold = req & ~wb_grant;
    end

    // Round-robin pointer: moves just past the winner, holds when idle.
    always_ff @(posedge clk) begin
        if (rst)        ptr <= '0;
        else if (found) ptr <= (gidx == PW'(NUM_FU - 1)) ? '0 : gidx + 1'b1;
    end

    // Sticky flag for a completion from a unit with nothing in flight.
    always_ff @(posedge clk) begin
        if (rst)                      err_spurious <= 1'b0;
        else if (|(fu_done & ~busy))  err_spurious <= 1'b1;
    end
endmodule

// File: tb/tb_fu_scoreboard.sv
// Directed bench for fu_scoreboard: a fixed-priority instance and a
// round-robin instance share issue inputs but have separate fu_done vectors.
module tb_fu_scoreboard;
    localparam int N  = 9;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          iv, iwr, irdfp, fp1, fp2, fp3, u1, u2, u3;
    logic [N-1:0]  ifu, done_f, done_r;
    logic [AW-1:0] ird, rs1, rs2, rs3;

    logic [N-1:0] gnt_f, hold_f, busy_f, gnt_r, hold_r, busy_r;
    logic         stall_f, acc_f, empty_f, err_f, stall_r, acc_r, empty_r, err_r;

    fu_scoreboard #(.NUM_FU(N), .REG_AW(AW), .RR_ARB(1'b0)) dut_f (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_fu(ifu), .issue_wr(iwr),
        .issue_rd(ird), .issue_rd_fp(irdfp), .rs1_id(rs1), .rs2_id(rs2), .rs3_id(rs3),
        .rs1_fp(fp1), .rs2_fp(fp2), .rs3_fp(fp3), .use_rs1(u1), .use_rs2(u2), .use_rs3(u3),
        .fu_done(done_f), .wb_grant(gnt_f), .fu_hold(hold_f), .issue_stall(stall_f),
        .issue_accept(acc_f), .busy(busy_f), .empty(empty_f), .err_spurious(err_f));

    fu_scoreboard #(.NUM_FU(N), .REG_AW(AW), .RR_ARB(1'b1)) dut_r (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_fu(ifu), .issue_wr(iwr),
        .issue_rd(ird), .issue_rd_fp(irdfp), .rs1_id(rs1), .rs2_id(rs2), .rs3_id(rs3),
        .rs1_fp(fp1), .rs2_fp(fp2), .rs3_fp(fp3), .use_rs1(u1), .use_rs2(u2), .use_rs3(u3),
        .fu_done(done_r), .wb_grant(gnt_r), .fu_hold(hold_r), .issue_stall(stall_r),
        .issue_accept(acc_r), .busy(busy_r), .empty(empty_r), .err_spurious(err_r));

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        iv = 1'b0; ifu = '0; iwr = 1'b0; ird = '0; irdfp = 1'b0;
        rs1 = '0; rs2 = '0; rs3 = '0; fp1 = 1'b0; fp2 = 1'b0; fp3 = 1'b0;
        u1 = 1'b0; u2 = 1'b0; u3 = 1'b0;
    endtask

    task automatic iss(input int fu, input logic wr, input logic [AW-1:0] rd, input logic fp);
        idle();
        iv = 1'b1; ifu = N'(1) << fu; iwr = wr; ird = rd; irdfp = fp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; idle(); done_f = '0; done_r = '0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_busy", busy_f, 9'h000);
        chk1("rst_empty", empty_f, 1'b1);
        chk("rst_grant", gnt_f, 9'h000);
        chk("rst_hold", hold_f, 9'h000);
        chk1("rst_stall", stall_f, 1'b0);
        chk1("rst_err", err_f, 1'b0);

        // back-to-back issue to unit 2
        iss(2, 1'b1, 5'd5, 1'b0); #1;
        chk1("b2b_acc0", acc_f, 1'b1);
        chk1("b2b_stall0", stall_f, 1'b0);
        tick();
        iss(2, 1'b1, 5'd6, 1'b0); #1;
        chk("b2b_busy", busy_f, 9'h004);
        chk1("b2b_stall1", stall_f, 1'b1);
        chk1("b2b_acc1", acc_f, 1'b0);
        tick(); #1;
        chk1("b2b_stall2", stall_f, 1'b1);
        done_f = 9'h004; #1;
        chk("b2b_grant", gnt_f, 9'h004);
        chk1("b2b_stall_gnt", stall_f, 1'b1);
        chk("b2b_hold", hold_f, 9'h000);
        tick();
        done_f = '0; #1;
        chk("b2b_busy_rel", busy_f, 9'h000);
        chk1("b2b_stall_rel", stall_f, 1'b0);
        chk1("b2b_acc_rel", acc_f, 1'b1);
        tick();
        idle(); #1;
        chk("b2b_busy2", busy_f, 9'h004);
        done_f = 9'h004;
        tick();
        done_f = '0; #1;
        chk("b2b_drain", busy_f, 9'h000);

        // RAW: unit 0 writes x7
        iss(0, 1'b1, 5'd7, 1'b0); #1;
        chk1("raw_acc_mul", acc_f, 1'b1);
        tick();
        iss(1, 1'b0, 5'd0, 1'b0); rs1 = 5'd7; u1 = 1'b1; #1;
        chk1("raw_x7", stall_f, 1'b1);
        fp1 = 1'b1; #1;
        chk1("raw_f7_vs_x7", stall_f, 1'b0);
        fp1 = 1'b0; u1 = 1'b0; #1;
        chk1("raw_unused", stall_f, 1'b0);
        rs2 = 5'd7; u2 = 1'b1; #1;
        chk1("raw_rs2", stall_f, 1'b1);
        iss(3, 1'b1, 5'd0, 1'b0); #1;
        chk1("raw_acc_x0", acc_f, 1'b1);
        tick();
        iss(6, 1'b1, 5'd0, 1'b1); #1;
        chk1("raw_acc_f0", acc_f, 1'b1);
        tick();
        iss(1, 1'b0, 5'd0, 1'b0); rs3 = 5'd0; fp3 = 1'b1; u3 = 1'b1; #1;
        chk("raw_busy3", busy_f, 9'h049);
        chk1("raw_f0_match", stall_f, 1'b1);
        fp3 = 1'b0; #1;
        chk1("raw_x0_nomatch", stall_f, 1'b0);
        iss(1, 1'b0, 5'd0, 1'b0); rs1 = 5'd7; u1 = 1'b1;
        done_f = 9'h049; #1;
        chk("raw_g0", gnt_f, 9'h001);
        chk("raw_h0", hold_f, 9'h048);
        chk1("raw_stall_gnt", stall_f, 1'b1);
        tick();
        done_f = 9'h048; #1;
        chk("raw_busy_g1", busy_f, 9'h048);
        chk("raw_g1", gnt_f, 9'h008);
        chk1("raw_stall_rel", stall_f, 1'b0);
        chk1("raw_acc_rel", acc_f, 1'b1);
        tick();
        idle(); done_f = 9'h042; #1;
        chk("raw_busy_g2", busy_f, 9'h042);
        chk("raw_g2", gnt_f, 9'h002);
        chk("raw_h2", hold_f, 9'h040);
        tick();
        done_f = 9'h040; #1;
        chk("raw_g3", gnt_f, 9'h040);
        tick();
        done_f = '0; #1;
        chk("raw_drain", busy_f, 9'h000);

        // WAW: unit 4 writes f3, unit 5 wants f3
        iss(4, 1'b1, 5'd3, 1'b1); #1;
        chk1("waw_acc_fdiv", acc_f, 1'b1);
        tick();
        iss(5, 1'b1, 5'd3, 1'b1); #1;
        chk1("waw_f3", stall_f, 1'b1);
        irdfp = 1'b0; #1;
        chk1("waw_x3", stall_f, 1'b0);
        irdfp = 1'b1; iwr = 1'b0; #1;
        chk1("waw_nowr", stall_f, 1'b0);
        iwr = 1'b1;
        tick(); #1;
        chk1("waw_hold", stall_f, 1'b1);
        done_f = 9'h010; #1;
        chk("waw_grant", gnt_f, 9'h010);
        chk1("waw_stall_gnt", stall_f, 1'b1);
        tick();
        done_f = '0; #1;
        chk1("waw_stall_rel", stall_f, 1'b0);
        chk1("waw_acc_rel", acc_f, 1'b1);
        tick();
        idle(); #1;
        chk("waw_busy", busy_f, 9'h020);
        done_f = 9'h020;
        tick();
        done_f = '0; #1;
        chk("waw_drain", busy_f, 9'h000);

        // collision, fixed priority
        iss(0, 1'b0, 5'd0, 1'b0); tick();
        iss(2, 1'b0, 5'd0, 1'b0); tick();
        iss(4, 1'b0, 5'd0, 1'b0); tick();
        idle(); #1;
        chk("col_busy", busy_f, 9'h015);
        done_f = 9'h015; #1;
        chk("col_g0", gnt_f, 9'h001);
        chk("col_h0", hold_f, 9'h014);
        tick();
        done_f = 9'h014; #1;
        chk("col_g1", gnt_f, 9'h004);
        chk("col_h1", hold_f, 9'h010);
        tick();
        done_f = 9'h010; #1;
        chk("col_g2", gnt_f, 9'h010);
        chk("col_h2", hold_f, 9'h000);
        tick();
        done_f = '0; #1;
        chk1("col_empty", empty_f, 1'b1);
        chk1("col_err", err_f, 1'b0);

        // reset during operation
        iss(1, 1'b1, 5'd10, 1'b0); tick();
        iss(2, 1'b1, 5'd11, 1'b0); tick();
        iss(3, 1'b1, 5'd12, 1'b0); tick();
        idle(); #1;
        chk("rdo_busy", busy_f, 9'h00e);
        chk1("rdo_empty0", empty_f, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("rdo_busy_clr", busy_f, 9'h000);
        chk1("rdo_empty", empty_f, 1'b1);
        chk("rdo_grant", gnt_f, 9'h000);
        chk1("rdo_err", err_f, 1'b0);
        chk("rdo_busy_r", busy_r, 9'h000);
        done_f = 9'h002; done_r = 9'h002; #1;
        chk("spur_grant", gnt_f, 9'h000);
        chk("spur_hold", hold_f, 9'h000);
        chk("spur_grant_r", gnt_r, 9'h000);
        tick(); #1;
        chk1("spur_err", err_f, 1'b1);
        chk1("spur_err_r", err_r, 1'b1);
        chk("spur_grant2", gnt_f, 9'h000);
        done_f = '0; done_r = '0;
        tick(); #1;
        chk1("spur_sticky", err_f, 1'b1);

        // round-robin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iss(2, 1'b0, 5'd0, 1'b0); #1;
        chk1("rr_acc", acc_r, 1'b1);
        tick();
        idle(); done_r = 9'h004; #1;
        chk("rr_g2", gnt_r, 9'h004);
        tick();
        done_r = '0;
        iss(1, 1'b0, 5'd0, 1'b0); tick();
        iss(4, 1'b0, 5'd0, 1'b0); tick();
        idle(); done_r = 9'h012; #1;
        chk("rr_busy", busy_r, 9'h012);
        chk("rr_g4", gnt_r, 9'h010);
        chk("rr_h4", hold_r, 9'h002);
        tick();
        done_r = 9'h002; #1;
        chk("rr_g1", gnt_r, 9'h002);
        chk("rr_h1", hold_r, 9'h000);
        tick();
        done_r = '0;
        iss(0, 1'b0, 5'd0, 1'b0); tick();
        iss(3, 1'b0, 5'd0, 1'b0); tick();
        idle(); done_r = 9'h009; #1;
        chk("rr_ptr2_g3", gnt_r, 9'h008);
        chk("rr_ptr2_h0", hold_r, 9'h001);
        tick();
        done_r = 9'h001; #1;
        chk("rr_g0", gnt_r, 9'h001);
        tick();
        done_r = '0; #1;
        chk("rr_drain", busy_r, 9'h000);
        chk1("rr_empty", empty_r, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/fu_scoreboard.md
# fu_scoreboard

Parametrised issue/writeback controller for the multicycle functional units in EXE (MulU, DivU, FAdd_Sub, FDiv, FSqrt, R4, ...). It generalises the fixed 9-unit priority scheme to NUM_FU units and records the destination of every in-flight operation. The recorded destinations are used for structural, RAW and WAW stalls at issue. A writeback arbiter, either fixed-priority or round-robin, serialises completions onto the single EXE→MEM result path.

## Interface
- NUM_FU, 9: number of multicycle functional units. Each unit holds at most one operation in flight.
- REG_AW, 5: register address width.
- RR_ARB, 0: writeback arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  the ID instruction targets a multicycle unit
- issue_fu  in  NUM_FU  one-hot target unit
- issue_wr  in  1  the instruction writes rd
- issue_rd  in  REG_AW  destination register
- issue_rd_fp  in  1  rd is in the FP register file
- rs1_id, rs2_id, rs3_id  in  REG_AW each  source registers
- rs1_fp, rs2_fp, rs3_fp  in  1 each  source is in the FP register file
- use_rs1, use_rs2, use_rs3  in  1 each  the source is actually read
- fu_done  in  NUM_FU  unit result valid; held high until granted
- wb_grant  out  NUM_FU  one-hot writeback select (p_sel)
- fu_hold  out  NUM_FU  unit is done but not granted; the unit must freeze
- issue_stall  out  1  stall the IF/ID stages and suppress issue
- issue_accept  out  1  equals issue_valid & ~issue_stall
- busy  out  NUM_FU  entry-valid vector
- empty  out  1  no entry valid (used for debug-halt drain)
- err_spurious  out  1  sticky; set when fu_done is high on a non-busy unit

## Operation
- Each unit i has one entry: busy[i], rd[i], rd_fp[i], wr[i].
- A match for source s against entry i requires all of the following:
  - use_s is high
  - busy[i] and wr[i] are high
  - rd[i] equals rs_s
  - rd_fp[i] equals rs_fp
  - the register is not integer x0; FP f0 is a real register and does match
- issue_stall is asserted when issue_valid is high and any of these hold:
  - structural: busy at the target unit, i.e. busy & issue_fu is non-zero
  - RAW: any source matches any entry
  - WAW: issue_wr is high and some entry has the same rd/rd_fp with wr set
- Hazard checks use the registered entries only. An entry granted this cycle still counts as busy this cycle.
- On issue_accept, the target entry loads busy=1 and rd/rd_fp/wr from the issue inputs at the next edge.
- Arbitration:
  - The request vector is req = fu_done & busy.
  - RR_ARB=0: grant goes to the lowest set index.
  - RR_ARB=1: a pointer ptr (reset 0) selects the first set index at or after ptr, wrapping modulo NUM_FU. After a grant to index g, ptr becomes (g+1) mod NUM_FU. ptr does not change when there is no request.
  - wb_grant is combinational and always zero or one-hot.
  - fu_hold = req & ~wb_grant.
- A granted entry clears busy at the next edge.
- Simultaneous grant and issue to the same unit in one cycle cannot occur, because the structural stall is still asserted.
- Reset: all entries are cleared and ptr=0. Every output is 0 except empty=1. err_spurious is cleared.
- Reset during operation discards all in-flight bookkeeping; the units are reset by the same rst.
- fu_done on a non-busy unit is never granted and sets err_spurious.

## Timing
- Issue accept at cycle t: busy[i] is visible from t+1. Dependent instructions stall from t+1.
- Single-cycle pulse: if fu_done[i] is high at cycle t and wins arbitration, wb_grant[i]=1 at t. busy[i]=0 and the stall is released at t+1, so the dependent instruction issues at t+1.
- Losing units: fu_hold stays high each cycle until the unit is granted.
- Worst-case wait with RR_ARB=1 is NUM_FU-1 cycles. Fixed-priority mode has no starvation bound.
- empty is registered-derived: empty = ~|busy.

## Test plan
1. Back-to-back issue: DIV to unit 2 (rd=x5), then any op to unit 2. Required: issue_stall=1 until the cycle after wb_grant[2]; the second op is accepted that cycle.
2. RAW: MUL on unit 0 writes x7, then an ADD-class op reads rs1=x7. Required: stall while busy[0]=1. Integer x7 versus FP f7 gives no stall. rd=x0 gives no stall.
3. WAW: FDIV on unit 4 (f3) is in flight, then FSQRT on unit 5 writes f3. Required: stall until busy[4] clears.
4. Collision: fu_done=9'b000010101 in one cycle with RR_ARB=0. Required: grant order is 0, 2, 4 on consecutive cycles. fu_hold starts at 9'b000010100, then 9'b000010000, then 0.
5. Round-robin with RR_ARB=1 and ptr=3: req={1,4}. Required: grant 4, then 1. ptr ends at 2.
6. Reset during operation: assert rst with 3 entries busy. Required: next cycle busy=0, empty=1, wb_grant=0 and err_spurious=0. After that, fu_done on unit 1 sets err_spurious and is never granted.
